// File: rtl/fir_decim_mc.sv
// Multichannel decimating FIR: one time-shared MAC per lane, results
// rounded, saturated and serialised on a stream master with backpressure.
module fir_decim_mc #(
   parameter int TAP_COUNT  = 121,
   parameter int DATA_WIDTH = 16,
   parameter int COEF_WIDTH = 16,
   parameter int DECIM      = 8,
   parameter int CHANNELS   = 16,
   parameter int ACC_WIDTH  = 48,
   parameter int OUT_SHIFT  = 15,
   parameter int OUT_WIDTH  = 16,
   parameter logic [TAP_COUNT*COEF_WIDTH-1:0] COEFS =
      (TAP_COUNT*COEF_WIDTH)'(2**(COEF_WIDTH-1)-1),
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                           clk,
   input  logic                           nrst,
   input  logic                           s_tvalid,
   output logic                           s_tready,
   input  logic [CHANNELS*DATA_WIDTH-1:0] s_tdata,
   output logic                           m_tvalid,
   input  logic                           m_tready,
   output logic [OUT_WIDTH-1:0]           m_tdata,
   output logic [CW-1:0]                  m_tchan,
   output logic                           m_tlast,
   output logic                           ovf
);

   localparam int KW     = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;
   localparam int PW     = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
   localparam int RSH    = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

   localparam logic signed [ACC_WIDTH:0] RND =
      (OUT_SHIFT > 0) ? ((ACC_WIDTH+1)'(1) <<< RSH) : '0;
   localparam logic signed [ACC_WIDTH:0] OMAX =
      (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
   localparam logic signed [ACC_WIDTH:0] OMIN = ~OMAX;

   typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

   state_t                       state;
   logic [PW-1:0]                phase;
   logic [KW-1:0]                k;
   logic signed [DATA_WIDTH-1:0] x    [CHANNELS][TAP_COUNT];
   logic signed [ACC_WIDTH-1:0]  acc  [CHANNELS];
   logic signed [OUT_WIDTH-1:0]  obuf [CHANNELS];

   logic signed [COEF_WIDTH-1:0] hk;
   logic signed [PROD_W-1:0]     prod [CHANNELS];
   logic signed [OUT_WIDTH-1:0]  rv   [CHANNELS];
   logic [CHANNELS-1:0]          clip;
   logic                         accept;
   logic                         last_beat;
   logic                         last_tap;
   logic                         last_chan;
   logic [CW-1:0]                nxt_chan;

   // Returns {clipped, value}: round half up, shift, clamp to OUT_WIDTH.
   function automatic logic [OUT_WIDTH:0] rnd_sat(
      input logic signed [ACC_WIDTH-1:0] a
   );
      logic signed [ACC_WIDTH:0] s;
      s = (ACC_WIDTH+1)'(a) + RND;
      s = s >>> OUT_SHIFT;
      if (s > OMAX)
         return {1'b1, OMAX[OUT_WIDTH-1:0]};
      if (s < OMIN)
         return {1'b1, OMIN[OUT_WIDTH-1:0]};
      return {1'b0, s[OUT_WIDTH-1:0]};
   endfunction

   assign accept    = s_tvalid && s_tready;
   assign last_beat = (phase == PW'(DECIM-1));
   assign last_tap  = (k == KW'(TAP_COUNT-1));
   assign last_chan = (m_tchan == CW'(CHANNELS-1));
   assign nxt_chan  = m_tchan + 1'b1;
   assign hk        = COEFS[int'(k)*COEF_WIDTH +: COEF_WIDTH];

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         prod[c] = PROD_W'(x[c][k]) * PROD_W'(hk);
         {clip[c], rv[c]} = rnd_sat(acc[c]);
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state    <= IDLE;
         phase    <= '0;
         k        <= '0;
         s_tready <= 1'b0;
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tchan  <= '0;
         m_tlast  <= 1'b0;
         ovf      <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            acc[c]  <= '0;
            obuf[c] <= '0;
            for (int i = 0; i < TAP_COUNT; i++)
               x[c][i] <= '0;
         end
      end else begin
         unique case (state)
            IDLE: begin
               s_tready <= 1'b1;
               if (accept) begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     x[c][0] <= s_tdata[c*DATA_WIDTH +: DATA_WIDTH];
                     for (int i = TAP_COUNT-1; i > 0; i--)
                        x[c][i] <= x[c][i-1];
                  end
                  if (last_beat) begin
                     phase    <= '0;
                     k        <= '0;
                     s_tready <= 1'b0;
                     state    <= MAC;
                     for (int c = 0; c < CHANNELS; c++)
                        acc[c] <= '0;
                  end else begin
                     phase <= phase + 1'b1;
                  end
               end
            end
            MAC: begin
               for (int c = 0; c < CHANNELS; c++)
                  acc[c] <= acc[c] + ACC_WIDTH'(prod[c]);
               k <= k + 1'b1;
               if (last_tap)
                  state <= ROUND;
            end
            ROUND: begin
               for (int c = 0; c < CHANNELS; c++)
                  obuf[c] <= rv[c];
               if (|clip)
                  ovf <= 1'b1;
               m_tvalid <= 1'b1;
               m_tchan  <= '0;
               m_tdata  <= rv[0];
               m_tlast  <= (CHANNELS == 1);
               state    <= OUT;
            end
            OUT: begin
               if (m_tready) begin
                  if (last_chan) begin
                     m_tvalid <= 1'b0;
                     m_tchan  <= '0;
                     m_tlast  <= 1'b0;
                     s_tready <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     m_tchan <= nxt_chan;
                     m_tdata <= obuf[nxt_chan];
                     m_tlast <= (nxt_chan == CW'(CHANNELS-1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
